mandel_view_ctrl: RTL and testbench

- Sequences the Mandelbrot render core from the two board buttons.
- Synchronises and debounces btn[1:0] and turns presses into zoom-level changes.
- Loads the new zoom level into the core over a valid/ready handshake, pulses a render start, and waits for the render to finish.
- Drives the board status LED high only when the displayed frame matches the current zoom. Sits in the FPGA toplevel between the button pins and the render core.

---
 rtl/mandel_view_ctrl.sv | 155 +++++++++++++++
 tb/tb_mandel_view_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mandel_view_ctrl.sv
// mandel_view_ctrl: turns the two board buttons into zoom-level changes for
// the Mandelbrot render core and sequences each frame.
//   sys_clk_pin  system clock
//   rst          asynchronous active-high reset (shared with the render core)
//   btn[1:0]     raw buttons: [0] zoom in, [1] zoom out
//   cfg_zoom     zoom level offered to the core, cfg_valid/cfg_ready handshake
//   render_start one-cycle frame start, render_done one-cycle end of frame
//   led          high while idle with the displayed frame up to date

// Per-button debouncer. The counter runs only while the synced level
// disagrees with the accepted level; any cycle of agreement clears it.
// 2^DEBOUNCE consecutive disagreeing cycles commit the new level.
module mvc_debounce #(
  parameter int DEBOUNCE = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic press_o
);
  localparam logic [DEBOUNCE-1:0] CNT_MAX = '1;

  logic [DEBOUNCE-1:0] cnt_q;
  logic                deb_q, deb_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      deb_prev_q <= deb_q;
      if (lvl_i == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= lvl_i;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = deb_q & ~deb_prev_q;
endmodule

module mandel_view_ctrl #(
  parameter int DEBOUNCE  = 20,
  parameter int ZOOM_W    = 3,
  parameter int ZOOM_MAX  = 7,
  parameter int ZOOM_INIT = 0
) (
  input  logic              sys_clk_pin,
  input  logic              rst,
  input  logic [1:0]        btn,
  output logic [ZOOM_W-1:0] cfg_zoom,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic              render_start,
  input  logic              render_done,
  output logic              led
);
  localparam logic [ZOOM_W-1:0] ZMAX  = ZOOM_W'(ZOOM_MAX);
  localparam logic [ZOOM_W-1:0] ZINIT = ZOOM_W'(ZOOM_INIT);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;

  state_e            state_q, state_d;
  logic [ZOOM_W-1:0] zoom_q, zoom_d;
  logic              pend_q, pend_d;
  logic              pdir_q, pdir_d;   // 1 = zoom in, 0 = zoom out
  logic              cfg_valid_q, render_start_q, led_q;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        press;
  logic              up_ok, dn_ok;

  always_ff @(posedge sys_clk_pin or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  mvc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb [1:0] (
    .clk_i  (sys_clk_pin),
    .rst_i  (rst),
    .lvl_i  (sync2_q),
    .press_o(press)
  );

  // Simultaneous presses cancel; out-of-range requests never get queued.
  assign up_ok = press[0] & ~press[1] & (zoom_q < ZMAX);
  assign dn_ok = press[1] & ~press[0] & (zoom_q != '0);

  always_comb begin
    state_d = state_q;
    zoom_d  = zoom_q;
    pend_d  = pend_q;
    pdir_d  = pdir_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          // Range is rechecked here; a request that no longer fits is dropped.
          if (pdir_q && zoom_q < ZMAX) begin
            zoom_d  = zoom_q + 1'b1;
            state_d = LOAD;
          end else if (!pdir_q && zoom_q != '0) begin
            zoom_d  = zoom_q - 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD:    if (cfg_valid_q && cfg_ready) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (render_done) state_d = IDLE;
      default: state_d = LOAD;
    endcase
    // Latest request wins, even over one being consumed this cycle.
    if (up_ok || dn_ok) begin
      pend_d = 1'b1;
      pdir_d = up_ok;
    end
  end

  // Outputs are registered from the next state so they read 0 during reset
  // even though the reset state is LOAD.
  always_ff @(posedge sys_clk_pin or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      zoom_q         <= ZINIT;
      pend_q         <= 1'b0;
      pdir_q         <= 1'b0;
      cfg_valid_q    <= 1'b0;
      render_start_q <= 1'b0;
      led_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      zoom_q         <= zoom_d;
      pend_q         <= pend_d;
      pdir_q         <= pdir_d;
      cfg_valid_q    <= (state_d == LOAD);
      render_start_q <= (state_d == START);
      led_q          <= (state_d == IDLE);
    end
  end

  assign cfg_zoom     = zoom_q;
  assign cfg_valid    = cfg_valid_q;
  assign render_start = render_start_q;
  assign led          = led_q;
endmodule

// File: tb/tb_mandel_view_ctrl.sv
module tb_mandel_view_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [2:0] cfg_zoom;
  logic       cfg_valid, render_start, led;
  logic       cfg_ready = 1'b1;
  logic       render_done = 1'b0;

  int nchk = 0, nerr = 0;
  int done_lat = 20;
  int n_load = 0, n_vcyc = 0, n_start = 0, bad_rise = 0, zoom_unst = 0;
  int l0, s0, v0;

  mandel_view_ctrl #(.DEBOUNCE(4), .ZOOM_W(3), .ZOOM_MAX(7), .ZOOM_INIT(0)) dut (
    .sys_clk_pin (clk),
    .rst         (rst),
    .btn         (btn),
    .cfg_zoom    (cfg_zoom),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .render_start(render_start),
    .render_done (render_done),
    .led         (led)
  );

  always #5 clk = ~clk;

  // Render core model: done pulse done_lat cycles after each start.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      render_done = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) render_done = 1'b1;
        end
        if (render_start) cnt = done_lat;
      end
    end
  end

  // Activity monitor sampled just after each active edge.
  initial begin
    logic d, pv, pl;
    logic [2:0] pz;
    pv = 1'b0; pl = 1'b0; pz = '0;
    forever begin
      @(posedge clk);
      d = render_done;
      #1;
      if (cfg_valid && !pv) n_load++;
      if (cfg_valid) n_vcyc++;
      if (render_start) n_start++;
      if (led && !pl && !d) bad_rise++;
      if (cfg_valid && pv && cfg_zoom !== pz) zoom_unst++;
      pv = cfg_valid; pl = led; pz = cfg_zoom;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] b, input int hold);
    @(negedge clk);
    btn = b;
    repeat (hold) @(negedge clk);
    btn = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_zoom", 32'(cfg_zoom), 0);
    chk("rst_valid", 32'(cfg_valid), 0);
    chk("rst_start", 32'(render_start), 0);
    chk("rst_led", 32'(led), 0);
    idle(3);
    rst = 1'b0;

    // Initial load of ZOOM_INIT
    idle(60);
    chk("init_loads", 32'(n_load), 1);
    chk("init_vcyc", 32'(n_vcyc), 1);
    chk("init_starts", 32'(n_start), 1);
    chk("init_zoom", 32'(cfg_zoom), 0);
    chk("init_led", 32'(led), 1);

    // Clean press of zoom-in
    l0 = n_load; s0 = n_start;
    press(2'b01, 30); idle(80);
    chk("in_loads", 32'(n_load - l0), 1);
    chk("in_starts", 32'(n_start - s0), 1);
    chk("in_zoom", 32'(cfg_zoom), 1);
    chk("in_led", 32'(led), 1);

    // Bouncing button never settles long enough
    l0 = n_load;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      btn[0] = ~btn[0];
      idle(5);
    end
    btn = 2'b00;
    idle(40);
    chk("bounce_loads", 32'(n_load - l0), 0);
    chk("bounce_zoom", 32'(cfg_zoom), 1);

    // Up to the top, then saturate
    for (int i = 0; i < 6; i++) begin
      press(2'b01, 30); idle(80);
    end
    chk("top_zoom", 32'(cfg_zoom), 7);
    l0 = n_load;
    press(2'b01, 30); idle(80);
    chk("top_sat_loads", 32'(n_load - l0), 0);
    chk("top_sat_zoom", 32'(cfg_zoom), 7);
    chk("top_sat_led", 32'(led), 1);

    // Down to the bottom, then saturate
    for (int i = 0; i < 7; i++) begin
      press(2'b10, 30); idle(80);
    end
    chk("bot_zoom", 32'(cfg_zoom), 0);
    l0 = n_load;
    press(2'b10, 30); idle(80);
    chk("bot_sat_loads", 32'(n_load - l0), 0);
    chk("bot_sat_zoom", 32'(cfg_zoom), 0);

    // Both buttons together cancel
    l0 = n_load;
    press(2'b11, 30); idle(80);
    chk("both_loads", 32'(n_load - l0), 0);
    chk("both_zoom", 32'(cfg_zoom), 0);

    // Latest request during a long render wins
    press(2'b01, 30); idle(80);
    chk("lw_pre_zoom", 32'(cfg_zoom), 1);
    done_lat = 200;
    l0 = n_load;
    press(2'b01, 30); idle(20);
    press(2'b01, 30); idle(20);
    press(2'b10, 30); idle(20);
    chk("lw_wait_zoom", 32'(cfg_zoom), 2);
    chk("lw_wait_led", 32'(led), 0);
    idle(300);
    chk("lw_zoom", 32'(cfg_zoom), 1);
    chk("lw_loads", 32'(n_load - l0), 2);
    chk("lw_led", 32'(led), 1);
    done_lat = 20;

    // Core stalls the handshake
    cfg_ready = 1'b0;
    s0 = n_start; v0 = n_vcyc;
    press(2'b01, 30); idle(50);
    chk("stall_valid", 32'(cfg_valid), 1);
    chk("stall_zoom", 32'(cfg_zoom), 2);
    chk("stall_starts", 32'(n_start - s0), 0);
    chk("stall_led", 32'(led), 0);
    chk("stall_vcyc_ge50", 32'(n_vcyc - v0 >= 50), 1);
    cfg_ready = 1'b1;
    idle(60);
    chk("stall_rel_starts", 32'(n_start - s0), 1);
    chk("stall_rel_led", 32'(led), 1);

    // Reset in the middle of a render
    done_lat = 200;
    press(2'b01, 30); idle(10);
    chk("mid_zoom", 32'(cfg_zoom), 3);
    chk("mid_led", 32'(led), 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_zoom", 32'(cfg_zoom), 0);
    chk("arst_valid", 32'(cfg_valid), 0);
    chk("arst_start", 32'(render_start), 0);
    chk("arst_led", 32'(led), 0);
    done_lat = 20;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("post_rst_valid", 32'(cfg_valid), 1);
    chk("post_rst_zoom", 32'(cfg_zoom), 0);
    idle(40);
    chk("post_rst_led", 32'(led), 1);
    chk("post_rst_zoom2", 32'(cfg_zoom), 0);

    chk("led_rise_after_done", 32'(bad_rise), 0);
    chk("zoom_stable_in_load", 32'(zoom_unst), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
